// File: rtl/alu_operand_stage.sv
// ALU operand-select stage.
//
// Builds operand A (RS1 / PC / zero) and operand B (RS2 / IMM / constant 4)
// from the register-file reads, forwarding younger results over the
// register file. Stalls while an operand that is actually used still waits
// on an in-flight load. Accepted bundles go into a 2-entry skid buffer with
// a valid/ready handshake, so the stage keeps one bundle per cycle under
// backpressure.
//
// Ports:
//   CLK, RST                   clock, synchronous active-high reset
//   IN_VALID / IN_READY        upstream handshake
//   RS1_ADDR, RS2_ADDR         source register indices
//   RS1_DATA, RS2_DATA         register-file read data
//   IMM, PC                    immediate and instruction address
//   A_SEL, B_SEL, IS_STORE     operand selects; RS2 is also store data
//   FWD_VALID/PEND/ADDR/DATA   forwarding sources, index 0 = youngest
//   FLUSH                      drop buffered and incoming bundles
//   OUT_VALID / OUT_READY      downstream handshake
//   OUT_A, OUT_B               registered operands (head entry)
//   OUT_STORE_DATA             registered forwarded RS2 (head entry)
//   HAZARD_STALL               load-use stall on the offered bundle
module alu_operand_stage #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned N_FWD      = 2,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         IN_VALID,
  output logic                         IN_READY,
  input  logic [REG_ADDR_W-1:0]        RS1_ADDR,
  input  logic [REG_ADDR_W-1:0]        RS2_ADDR,
  input  logic [XLEN-1:0]              RS1_DATA,
  input  logic [XLEN-1:0]              RS2_DATA,
  input  logic [XLEN-1:0]              IMM,
  input  logic [XLEN-1:0]              PC,
  input  logic [1:0]                   A_SEL,
  input  logic [1:0]                   B_SEL,
  input  logic                         IS_STORE,
  input  logic [N_FWD-1:0]             FWD_VALID,
  input  logic [N_FWD-1:0]             FWD_PEND,
  input  logic [N_FWD*REG_ADDR_W-1:0]  FWD_ADDR,
  input  logic [N_FWD*XLEN-1:0]        FWD_DATA,
  input  logic                         FLUSH,
  output logic                         OUT_VALID,
  input  logic                         OUT_READY,
  output logic [XLEN-1:0]              OUT_A,
  output logic [XLEN-1:0]              OUT_B,
  output logic [XLEN-1:0]              OUT_STORE_DATA,
  output logic                         HAZARD_STALL
);

  // Buffer occupancy doubles as the entry count.
  localparam logic [1:0] StEmpty = 2'd0;
  localparam logic [1:0] StOne   = 2'd1;
  localparam logic [1:0] StTwo   = 2'd2;

  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] sd;
  } bundle_t;

  logic [1:0]      state_q, state_d;
  bundle_t         head_q, head_d;
  bundle_t         tail_q, tail_d;
  bundle_t         in_bundle;
  logic [XLEN-1:0] rs1_val, rs2_val;
  logic            rs1_pend, rs2_pend;
  logic            rs1_used, rs2_used;
  logic            hazard;
  logic            push, pop;

  // Scan from the oldest source down so the youngest match is written last
  // and wins. Register 0 is hard-wired and never forwarded.
  always_comb begin
    rs1_val  = RS1_DATA;
    rs2_val  = RS2_DATA;
    rs1_pend = 1'b0;
    rs2_pend = 1'b0;
    for (int i = N_FWD - 1; i >= 0; i--) begin
      if (FWD_VALID[i] && (FWD_ADDR[i*REG_ADDR_W +: REG_ADDR_W] == RS1_ADDR) &&
          (RS1_ADDR != '0)) begin
        rs1_val  = FWD_DATA[i*XLEN +: XLEN];
        rs1_pend = FWD_PEND[i];
      end
      if (FWD_VALID[i] && (FWD_ADDR[i*REG_ADDR_W +: REG_ADDR_W] == RS2_ADDR) &&
          (RS2_ADDR != '0)) begin
        rs2_val  = FWD_DATA[i*XLEN +: XLEN];
        rs2_pend = FWD_PEND[i];
      end
    end
  end

  assign rs1_used     = (A_SEL == 2'b00);
  assign rs2_used     = (B_SEL == 2'b00) || IS_STORE;
  assign hazard       = (rs1_used && rs1_pend) || (rs2_used && rs2_pend);
  assign HAZARD_STALL = IN_VALID && hazard;

  always_comb begin
    in_bundle.sd = rs2_val;
    case (A_SEL)
      2'b00:   in_bundle.a = rs1_val;
      2'b01:   in_bundle.a = PC;
      default: in_bundle.a = '0;
    endcase
    case (B_SEL)
      2'b00:   in_bundle.b = rs2_val;
      2'b10:   in_bundle.b = XLEN'(4);
      default: in_bundle.b = IMM;
    endcase
  end

  assign IN_READY  = (state_q != StTwo) && !hazard && !FLUSH;
  assign OUT_VALID = (state_q != StEmpty);
  assign push      = IN_VALID && IN_READY;
  assign pop       = OUT_VALID && OUT_READY;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (FLUSH) begin
      state_d = StEmpty;
    end else begin
      case (state_q)
        StEmpty: begin
          if (push) begin
            state_d = StOne;
            head_d  = in_bundle;
          end
        end
        StOne: begin
          if (push && !pop) begin
            state_d = StTwo;
            tail_d  = in_bundle;
          end else if (pop && !push) begin
            state_d = StEmpty;
          end else if (push && pop) begin
            head_d = in_bundle;
          end
        end
        StTwo: begin
          if (pop) begin
            state_d = StOne;
            head_d  = tail_q;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StEmpty;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  assign OUT_A          = head_q.a;
  assign OUT_B          = head_q.b;
  assign OUT_STORE_DATA = head_q.sd;

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
Parametrised ALU operand-select stage for the pipelined core. It builds operand A (RS1/PC/zero) and operand B (RS2/immediate/constant 4), with register-result forwarding from N_FWD younger pipeline stages and load-use hazard detection. Results are registered into a 2-entry skid buffer with a valid/ready handshake. It sits between decode/register-read and the ALU, and supports full throughput under backpressure.

Parameters:
XLEN, 32, datapath width in bits
N_FWD, 2, number of forwarding sources; index 0 is the youngest stage and has the highest priority
REG_ADDR_W, 5, register address width

Ports:
CLK  in  1  clock
RST  in  1  synchronous active-high reset
IN_VALID  in  1  upstream operand bundle valid
IN_READY  out  1  stage accepts bundle this cycle
RS1_ADDR  in  REG_ADDR_W  source register 1 index
RS2_ADDR  in  REG_ADDR_W  source register 2 index
RS1_DATA  in  XLEN  register-file read 1
RS2_DATA  in  XLEN  register-file read 2
IMM  in  XLEN  sign-extended immediate
PC  in  XLEN  instruction address
A_SEL  in  2  00 RS1, 01 PC, 1x zero
B_SEL  in  2  00 RS2, 01 IMM, 10 constant 4, 11 IMM
IS_STORE  in  1  RS2 needed as store data
FWD_VALID  in  N_FWD  source i writes a register
FWD_PEND  in  N_FWD  source i result not yet available (load in flight)
FWD_ADDR  in  N_FWD*REG_ADDR_W  destination index per source, packed with source i at [i*REG_ADDR_W +: REG_ADDR_W]
FWD_DATA  in  N_FWD*XLEN  result per source, packed the same way
FLUSH  in  1  discard buffered and incoming bundles
OUT_VALID  out  1  head entry valid
OUT_READY  in  1  ALU consumes head
OUT_A  out  XLEN  operand A
OUT_B  out  XLEN  operand B
OUT_STORE_DATA  out  XLEN  forwarded RS2 value
HAZARD_STALL  out  1  load-use stall asserted this cycle

Behaviour:
- Forwarding, per operand rs:
  - Scan i = 0..N_FWD-1.
  - The first i with FWD_VALID[i] and FWD_ADDR[i]==rs and rs!=0 wins.
  - If nothing matches, use the register-file value. rs==0 is never forwarded.
- Hazard:
  - rs1_used = (A_SEL==00). rs2_used = (B_SEL==00) or IS_STORE.
  - A hazard exists when a used operand's winning source has FWD_PEND=1.
  - Unused operands never cause a stall.
  - HAZARD_STALL = IN_VALID and hazard (combinational).
- Operand A: forwarded RS1 for 00, PC for 01, 0 for 1x.
- Operand B: forwarded RS2 for 00, IMM for 01 and 11, 32'd4 (XLEN-wide) for 10.
- OUT_STORE_DATA is always the forwarded RS2.
- Buffer:
  - States EMPTY, ONE, TWO, with count 0/1/2.
  - IN_READY = (count<2) and !hazard and !FLUSH.
  - push = IN_VALID and IN_READY.
  - pop = OUT_VALID and OUT_READY.
  - OUT_VALID = count!=0. Outputs come from the head entry, which is registered.
- Transitions:
  - EMPTY: push -> ONE.
  - ONE: push and no pop -> TWO. Pop and no push -> EMPTY. Push and pop together -> ONE, with the new bundle becoming the head.
  - TWO: pop -> ONE, and the second entry moves to head. No push is possible in TWO.
- Latency: a bundle accepted in cycle n appears on OUT in cycle n+1 when the buffer was empty. Order is strictly FIFO.
- FLUSH: takes priority over push and pop. count becomes 0 next cycle and no push occurs that cycle. Data registers may hold stale values but OUT_VALID=0.
- RST:
  - Overrides everything, including mid-transfer.
  - Next cycle: count=0, OUT_VALID=0, OUT_A/OUT_B/OUT_STORE_DATA=0, both entries cleared.
  - IN_READY=1 once the stage is out of reset, provided no hazard and no FLUSH.
- Output holds stable while OUT_VALID and !OUT_READY.

Test Plan:
- Basic: A_SEL=00, B_SEL=01, RS1_ADDR=3, RS1_DATA=0x10, IMM=0xFFFFFFFC, no forwarding, OUT_READY=1 -> next cycle OUT_VALID=1, OUT_A=0x10, OUT_B=0xFFFFFFFC.
- Forwarding priority: RS1_ADDR=5, FWD0 {addr 5, 0xAAAA}, FWD1 {addr 5, 0xBBBB} -> OUT_A=0xAAAA.
  - Drop FWD0 -> OUT_A=0xBBBB.
  - RS1_ADDR=0 with FWD0 addr 0 -> OUT_A=RS1_DATA.
  - B_SEL=10 -> OUT_B=4.
- Load-use: RS2_ADDR=7, B_SEL=00, FWD0 {addr 7, pend 1} -> HAZARD_STALL=1, IN_READY=0, no push.
  - Clear pend with data 0x55 -> accepted, OUT_B=0x55.
  - Same hazard with B_SEL=01 and IS_STORE=0 -> no stall.
- Backpressure: OUT_READY=0, offer bundles X, Y, Z -> X and Y accepted, IN_READY=0 while Z is held.
  - Raise OUT_READY -> X, Y, Z emerge in order on consecutive cycles.
  - Push and pop together in ONE -> throughput of one per cycle.
- Flush: count=2 and IN_VALID=1 with FLUSH=1 -> next cycle OUT_VALID=0, the incoming bundle is dropped, and IN_READY=1.
- Reset mid-operation: count=2 and OUT_READY=0, assert RST one cycle -> OUT_VALID=0, OUT_A=OUT_B=0. The following push yields only the new bundle.
